program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//   Upstream write stage for the 16x8 TD4 program memory. Accepts a program as a
//   stream of 4-bit nibbles over a valid/ready handshake from the chip pins and
//   packs each opcode/immediate pair into one memory word. It writes the 16 words
//   sequentially and holds the CPU in reset-like hold while loading. Once idle,
//   it passes the CPU program counter through as the memory address.
// PARAMETERS
//   ADDR_W   4    memory address width
//   DEPTH    16   number of words to load; last address = DEPTH-1
//   NIB_W    4    width of opcode and immediate fields
// PORTS
//   clk            in   1       clock, rising edge
//   rst_n          in   1       reset, asynchronous, active-low
//   load_start     in   1       level; 1 = request/remain in load mode
//   in_valid       in   1       nibble on in_nibble is valid
//   in_nibble      in   NIB_W   program nibble: opcode first, then immediate
//   in_ready       out  1       loader accepts a nibble this cycle
//   pc_in          in   ADDR_W  CPU program counter; used as the address when IDLE
//   mem_address    out  ADDR_W  to memory address
//   mem_opcode     out  NIB_W   to memory opcode_in
//   mem_immediate  out  NIB_W   to memory immediate_in
//   mem_write      out  1       one-cycle write strobe to memory
//   cpu_hold       out  1       1 = CPU must not advance (any state but IDLE)
//   load_done      out  1       1 = all DEPTH words written; held in DONE
//   word_count     out  ADDR_W+1  words written in the current load, 0..DEPTH
// BEHAVIOUR
//   Reset:
//   - state IDLE; addr_q=0; op_q=0; imm_q=0; word_count=0.
//   - mem_write=0; load_done=0; cpu_hold=0; in_ready=0.
//   Handshake:
//   - A transfer occurs on a rising edge with in_valid && in_ready.
//   - in_ready is 1 only in S_OP and S_IMM, and is combinational from the state.
//   - in_valid with in_ready=0 is ignored; no stall state exists.
//   FSM (registered state):
//   - IDLE: mem_address=pc_in; mem_write=0.
//       load_start=1 -> S_OP; addr_q<=0; word_count<=0.
//   - S_OP: on transfer, op_q<=in_nibble -> S_IMM.
//   - S_IMM: on transfer, imm_q<=in_nibble -> S_WR.
//   - S_WR: mem_write=1 for exactly one cycle, with mem_address=addr_q,
//       mem_opcode=op_q and mem_immediate=imm_q (memory packs {imm,op}).
//       word_count<=word_count+1.
//       If addr_q==DEPTH-1 -> DONE; else addr_q<=addr_q+1 -> S_OP.
//   - DONE: load_done=1; mem_address=addr_q.
//       load_start=0 -> IDLE; load_done drops in that same transition.
//   Output timing:
//   - In all non-IDLE states, mem_address=addr_q and cpu_hold=1.
//   - The mem_address mux is combinational.
//   - mem_opcode and mem_immediate are driven from op_q/imm_q at all times.
//   Abort:
//   - load_start=0 in S_OP, S_IMM or S_WR -> IDLE on the next edge, without
//     writing a partial word. In S_WR, the strobe already asserted completes.
//   - Words already written stay in memory. word_count holds its value until the
//     next load starts.
//   Boundaries:
//   - addr_q never wraps; DONE is terminal until load_start=0.
//   - A new load requires load_start to drop to 0 and then rise again; it always
//     restarts at address 0.
//   - Minimum per word is 3 cycles (OP, IMM, WR). A full load is >= 3*DEPTH cycles.
//   - Asynchronous reset mid-load returns to IDLE immediately and clears
//     mem_write combinationally with the state.
// TESTING
//   1. Reset: rst_n=0 -> all outputs 0. Check mem_address==pc_in (pc_in=4'h9 -> 4'h9).
//   2. Full load of 32 nibbles, valid held high: expect 16 mem_write pulses at
//      addr 0..15. Word k = {imm=~k, op=k}. load_done=1 and word_count=16 after
//      cycle 48.
//   3. Gappy valid: toggle in_valid randomly over the word pair (op=4'h3, imm=4'hA).
//      Expect exactly one write of 8'hA3 at addr 0, and no write while in_valid=0.
//   4. Abort: drop load_start after 5 words plus one opcode nibble. Expect state
//      IDLE, word_count=5, no write at addr 5, cpu_hold=0.
//   5. Restart: after DONE, drop load_start, then raise it. Expect addr restart at
//      0 and word_count cleared to 0.
//   6. Reset mid-S_WR: assert rst_n=0 during the strobe. Expect mem_write=0 at once,
//      and IDLE after release.

Source files
------------

// File: rtl/program_loader.sv
// Streams opcode/immediate nibble pairs into the 16x8 TD4 program memory and
// holds the CPU while loading; passes the CPU program counter through when idle.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [NIB_W-1:0]  in_nibble,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic [NIB_W-1:0]  mem_opcode,
    output logic [NIB_W-1:0]  mem_immediate,
    output logic              mem_write,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] S_OP  = 3'd1;
    localparam logic [2:0] S_IMM = 3'd2;
    localparam logic [2:0] S_WR  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NIB_W-1:0]  op_q, op_d;
    logic [NIB_W-1:0]  imm_q, imm_d;
    logic [ADDR_W:0]   count_q, count_d;

    // Dropping load_start aborts any in-progress load; a word already in S_WR
    // still gets its strobe, so it is counted.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        imm_d   = imm_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = S_OP;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            S_OP: begin
                if (in_valid) begin
                    op_d = in_nibble;
                end
                if (!load_start) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    state_d = S_IMM;
                end
            end
            S_IMM: begin
                if (in_valid) begin
                    imm_d = in_nibble;
                end
                if (!load_start) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                count_d = count_q + COUNT_ONE;
                if (!load_start) begin
                    state_d = IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_OP;
                end
            end
            DONE: begin
                if (!load_start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            imm_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            count_q <= count_d;
        end
    end

    // All outputs decode straight from the registered state so that reset
    // clears the write strobe without waiting for a clock edge.
    always_comb begin
        in_ready      = (state_q == S_OP) || (state_q == S_IMM);
        mem_write     = (state_q == S_WR);
        cpu_hold      = (state_q != IDLE);
        load_done     = (state_q == DONE);
        mem_address   = (state_q == IDLE) ? pc_in : addr_q;
        mem_opcode    = op_q;
        mem_immediate = imm_q;
        word_count    = count_q;
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: reset, full load, gappy
// handshake, restart, abort and asynchronous reset during a write strobe.
module tb_program_loader;

    logic       clk;
    logic       rst_n;
    logic       load_start;
    logic       in_valid;
    logic [3:0] in_nibble;
    logic       in_ready;
    logic [3:0] pc_in;
    logic [3:0] mem_address;
    logic [3:0] mem_opcode;
    logic [3:0] mem_immediate;
    logic       mem_write;
    logic       cpu_hold;
    logic       load_done;
    logic [4:0] word_count;

    int checks = 0;
    int errors = 0;
    int wrCount = 0;
    logic [7:0] tbMem [16];

    program_loader #(.ADDR_W(4), .DEPTH(16), .NIB_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .in_valid      (in_valid),
        .in_nibble     (in_nibble),
        .in_ready      (in_ready),
        .pc_in         (pc_in),
        .mem_address   (mem_address),
        .mem_opcode    (mem_opcode),
        .mem_immediate (mem_immediate),
        .mem_write     (mem_write),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .word_count    (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: captures every strobe mid-cycle, like the real memory would.
    always @(negedge clk) begin
        if (mem_write) begin
            wrCount = wrCount + 1;
            tbMem[mem_address] = {mem_immediate, mem_opcode};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish in time");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one nibble and waits (bounded) until it is accepted.
    task automatic sendNibble(input logic [3:0] n);
        int waitCycles;
        in_valid  = 1'b1;
        in_nibble = n;
        waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbMem[i] = 8'h00;
        rst_n      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_nibble  = 4'h0;
        pc_in      = 4'h9;
        #3;

        // Reset state
        check("rst_mem_write",  {31'd0, mem_write}, 32'd0);
        check("rst_load_done",  {31'd0, load_done}, 32'd0);
        check("rst_cpu_hold",   {31'd0, cpu_hold}, 32'd0);
        check("rst_in_ready",   {31'd0, in_ready}, 32'd0);
        check("rst_word_count", {27'd0, word_count}, 32'd0);
        check("rst_opcode",     {28'd0, mem_opcode}, 32'd0);
        check("rst_immediate",  {28'd0, mem_immediate}, 32'd0);
        check("rst_mem_address",{28'd0, mem_address}, 32'h9);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_address_pc", {28'd0, mem_address}, 32'h9);

        // Full load, valid held high: word k = {~k, k}
        load_start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kn;
            kn = 4'(k);
            sendNibble(kn);
            sendNibble(~kn);
        end
        check("full_in_wr", {31'd0, mem_write}, 32'd1);
        check("full_wr_addr", {28'd0, mem_address}, 32'hF);
        tick();
        check("full_load_done", {31'd0, load_done}, 32'd1);
        check("full_word_count", {27'd0, word_count}, 32'd16);
        check("full_wr_count", wrCount, 32'd16);
        check("full_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("full_done_ready", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kn;
            kn = 4'(k);
            check($sformatf("full_word_%0d", k), {24'd0, tbMem[k]}, {24'd0, ~kn, kn});
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("done_terminal", {31'd0, load_done}, 32'd1);
        check("done_no_write", wrCount, 32'd16);

        // Restart: drop load_start, then raise it again
        load_start = 1'b0;
        tick();
        check("restart_idle_done", {31'd0, load_done}, 32'd0);
        check("restart_idle_hold", {31'd0, cpu_hold}, 32'd0);
        check("restart_count_held", {27'd0, word_count}, 32'd16);
        pc_in = 4'h6;
        #1;
        check("restart_idle_pc", {28'd0, mem_address}, 32'h6);
        load_start = 1'b1;
        tick();
        check("restart_count_clr", {27'd0, word_count}, 32'd0);
        check("restart_addr0", {28'd0, mem_address}, 32'h0);
        check("restart_hold", {31'd0, cpu_hold}, 32'd1);

        // Gappy valid on one word (op=3, imm=A)
        wrCount = 0;
        in_valid = 1'b0;
        tick();
        tick();
        check("gap_op_wait_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_nibble = 4'h3;
        tick();
        in_valid = 1'b0;
        in_nibble = 4'hF;
        tick();
        tick();
        check("gap_imm_wait_ready", {31'd0, in_ready}, 32'd1);
        check("gap_no_write_yet", wrCount, 32'd0);
        in_valid = 1'b1;
        in_nibble = 4'hA;
        tick();
        in_valid = 1'b0;
        check("gap_strobe", {31'd0, mem_write}, 32'd1);
        check("gap_strobe_addr", {28'd0, mem_address}, 32'h0);
        tick();
        check("gap_one_write", wrCount, 32'd1);
        check("gap_word", {24'd0, tbMem[0]}, 32'hA3);
        check("gap_count", {27'd0, word_count}, 32'd1);
        check("gap_next_addr", {28'd0, mem_address}, 32'h1);

        // Abort after 5 words plus an opcode nibble
        for (int k = 1; k < 5; k++) begin
            logic [3:0] kn;
            kn = 4'(k);
            sendNibble(kn);
            sendNibble(4'h5);
        end
        sendNibble(4'hC);
        load_start = 1'b0;
        in_valid = 1'b0;
        tick();
        check("abort_hold", {31'd0, cpu_hold}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd0);
        check("abort_count", {27'd0, word_count}, 32'd5);
        check("abort_pc", {28'd0, mem_address}, 32'h6);
        tick();
        tick();
        check("abort_wr_count", wrCount, 32'd5);
        check("abort_word4", {24'd0, tbMem[4]}, 32'h54);
        check("abort_no_addr5", {24'd0, tbMem[5]}, 32'hA5);

        // Asynchronous reset during the write strobe
        load_start = 1'b1;
        tick();
        sendNibble(4'h7);
        sendNibble(4'h2);
        in_valid = 1'b0;
        check("rstwr_strobe", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstwr_write_clr", {31'd0, mem_write}, 32'd0);
        check("rstwr_hold_clr", {31'd0, cpu_hold}, 32'd0);
        check("rstwr_count_clr", {27'd0, word_count}, 32'd0);
        load_start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rstwr_idle_hold", {31'd0, cpu_hold}, 32'd0);
        check("rstwr_idle_pc", {28'd0, mem_address}, 32'h6);
        check("rstwr_idle_ready", {31'd0, in_ready}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
